gpgpu_obi_arbiter: RTL and testbench
====================================

// Module: gpgpu_obi_arbiter
// PURPOSE
//  N-to-1 OBI memory-port arbiter with in-order response routing.
//  Merges NUM_PORTS requesters onto one OBI master, e.g. several cores onto one instr/data port of the cache hierarchy.
//  Round-robin grant; address phase held stable until gnt; outstanding-port FIFO routes rvalid/rdata back.
// PARAMETERS
//  NUM_PORTS        4   number of requester (slave) ports, >=2
//  ADDR_WIDTH       32  OBI address width
//  DATA_WIDTH       32  OBI data width; BE width = DATA_WIDTH/8
//  MAX_OUTSTANDING  4   max accepted-but-unanswered transactions, >=1
// PORTS
//  clk_i            in   1            clock
//  rst_i            in   1            reset, synchronous, active-high
//  s_req_i          in   NUM_PORTS    per-port request
//  s_gnt_o          out  NUM_PORTS    per-port grant
//  s_addr_i         in   NUM_PORTS*AW packed per-port address
//  s_we_i           in   NUM_PORTS    per-port write enable
//  s_be_i           in   NUM_PORTS*BW packed per-port byte enables
//  s_wdata_i        in   NUM_PORTS*DW packed per-port write data
//  s_rvalid_o       out  NUM_PORTS    per-port response valid
//  s_rdata_o        out  DW           shared response data, qualified by s_rvalid_o
//  m_req_o          out  1            master request
//  m_gnt_i          in   1            master grant
//  m_addr_o/m_we_o/m_be_o/m_wdata_o  out  AW/1/BW/DW  muxed from winner
//  m_rvalid_i       in   1            master response valid (in order, >=1 cycle after gnt)
//  m_rdata_i        in   DW           master response data
//  err_o            out  1            sticky protocol-error flag
// BEHAVIOUR
//  Reset (rst_i high at posedge): rr_ptr=0, lock clear, FIFO empty, err_o=0.
//   While rst_i is high, m_req_o, s_gnt_o and s_rvalid_o are forced 0.
//  Winner selection:
//   - If lock set: winner=lock_idx.
//   - Else: first asserted s_req_i scanning from rr_ptr upward, wrapping at NUM_PORTS.
//  m_req_o = winner valid && !fifo_full. m_* payload is taken from the winner.
//  Handshake = m_req_o && m_gnt_i. s_gnt_o[winner] = handshake; all other s_gnt_o bits stay 0.
//  On handshake: push winner idx into FIFO; rr_ptr <= winner+1 (wrap to 0); lock cleared.
//  If m_req_o && !m_gnt_i: lock set, lock_idx=winner. This keeps the address phase stable per OBI.
//  Locked port drops s_req_i before gnt: err_o set, lock cleared, m_req_o follows the new RR winner that same cycle.
//  Response: s_rvalid_o[p] = m_rvalid_i && !empty && head==p. s_rdata_o = m_rdata_i (combinational, 0-cycle).
//   Pop on m_rvalid_i && !empty.
//  m_rvalid_i while FIFO empty: ignored (no s_rvalid_o), err_o set.
//  Full: no new m_req_o, even if a pop happens in the same cycle (no rvalid->req comb path).
//   Request resumes the next cycle.
//  Push and pop in the same cycle: count unchanged, both pointers advance.
//  Pointers wrap modulo MAX_OUTSTANDING; count is $clog2(MAX_OUTSTANDING+1) bits.
//  Latency: 0-cycle request path (comb mux) when unlocked; response path 0-cycle.
//  Reset mid-transaction: outstanding entries are discarded; later m_rvalid_i counts as an error.
//   The system resets the memory side together with this block.
//  err_o is cleared only by reset.
// STRUCTURE
//  Package gpgpu_arb_pkg: IDX_W=$clog2(NUM_PORTS) (min 1), CNT_W function, and the obi_payload_t struct {addr,we,be,wdata}.
//  Sub-module gpgpu_idx_fifo: synchronous FIFO of IDX_W-bit entries, depth MAX_OUTSTANDING.
//   Ports: push/pop/head/full/empty; no fall-through.
//  Top holds the RR pointer, lock register, winner mux, and error flag.
// TESTING
//  1 Ports 0,2 request; m_gnt_i=1 -> port0 granted cycle0, port2 cycle1; rr_ptr=3 after.
//    rvalids route to port 0 then port 2.
//  2 Port1 requests, m_gnt_i=0 for 3 cycles while port0 also requests.
//    -> m_addr_o stays port1 addr; port1 granted on cycle 3; then port0.
//  3 All 4 ports request, m_gnt_i=1, no rvalid (MAX_OUTSTANDING=4).
//    -> 4 grants, then m_req_o=0. One rvalid -> next cycle m_req_o=1.
//  4 Full FIFO, rvalid in the same cycle as a pending request -> no grant that cycle; grant next cycle; count stays 4.
//  5 m_rvalid_i with empty FIFO -> all s_rvalid_o=0, err_o=1 and sticky until rst_i.
//  6 rst_i asserted with 2 outstanding -> outputs 0. After release a stray rvalid sets err_o; new port3 request is granted first.

Source files
------------

// File: rtl/gpgpu_arb_pkg.sv
// Shared types and width helpers for the OBI arbiter: payload struct and
// index/count width functions.
package gpgpu_arb_pkg;

    localparam int unsigned OBI_AW = 32;
    localparam int unsigned OBI_DW = 32;
    localparam int unsigned OBI_BW = OBI_DW / 8;

    // Port index width, never narrower than one bit.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int unsigned cnt_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    typedef struct packed {
        logic [OBI_AW-1:0] addr;
        logic              we;
        logic [OBI_BW-1:0] be;
        logic [OBI_DW-1:0] wdata;
    } obi_payload_t;

endpackage

// File: rtl/gpgpu_idx_fifo.sv
// Synchronous FIFO of port indices; head is registered storage, no fall-through.
module gpgpu_idx_fifo
    import gpgpu_arb_pkg::*;
#(
    parameter int unsigned WIDTH = 2,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned PTR_W = (DEPTH <= 1) ? 1 : $clog2(DEPTH);
    localparam int unsigned CNT_W = cnt_w(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + 1'b1;
            end else if (do_pop && !do_push) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/gpgpu_obi_arbiter.sv
// N-to-1 OBI arbiter: round-robin grant with address-phase lock, and an
// outstanding-index FIFO that steers in-order responses back to requesters.
module gpgpu_obi_arbiter
    import gpgpu_arb_pkg::*;
#(
    parameter int unsigned NUM_PORTS       = 4,
    parameter int unsigned ADDR_WIDTH      = OBI_AW,
    parameter int unsigned DATA_WIDTH      = OBI_DW,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic [NUM_PORTS-1:0]               s_req_i,
    output logic [NUM_PORTS-1:0]               s_gnt_o,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]    s_addr_i,
    input  logic [NUM_PORTS-1:0]               s_we_i,
    input  logic [NUM_PORTS*DATA_WIDTH/8-1:0]  s_be_i,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]    s_wdata_i,
    output logic [NUM_PORTS-1:0]               s_rvalid_o,
    output logic [DATA_WIDTH-1:0]              s_rdata_o,
    output logic                               m_req_o,
    input  logic                               m_gnt_i,
    output logic [ADDR_WIDTH-1:0]              m_addr_o,
    output logic                               m_we_o,
    output logic [DATA_WIDTH/8-1:0]            m_be_o,
    output logic [DATA_WIDTH-1:0]              m_wdata_o,
    input  logic                               m_rvalid_i,
    input  logic [DATA_WIDTH-1:0]              m_rdata_i,
    output logic                               err_o
);

    localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;
    localparam int unsigned IDX_W    = idx_w(NUM_PORTS);

    logic [IDX_W-1:0] rr_ptr_q, lock_idx_q, rr_idx, win_idx, fifo_head;
    logic             lock_q, err_q;
    logic             rr_valid, lock_hold, lock_drop, win_valid;
    logic             fifo_full, fifo_empty, handshake, rsp_ok;
    obi_payload_t     win_pl;

    // Round-robin scan starting at rr_ptr_q, wrapping at NUM_PORTS.
    always_comb begin
        int unsigned j;
        j        = 0;
        rr_valid = 1'b0;
        rr_idx   = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            j = (32'(rr_ptr_q) + i) % NUM_PORTS;
            if (!rr_valid && s_req_i[j]) begin
                rr_valid = 1'b1;
                rr_idx   = IDX_W'(j);
            end
        end
    end

    // A locked port keeps the bus until granted; if it withdraws, fall back to RR.
    assign lock_hold = lock_q && s_req_i[lock_idx_q];
    assign lock_drop = lock_q && !s_req_i[lock_idx_q];
    assign win_valid = lock_hold || rr_valid;
    assign win_idx   = lock_hold ? lock_idx_q : rr_idx;

    always_comb begin
        win_pl = '0;
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            if (IDX_W'(p) == win_idx) begin
                win_pl.addr  = s_addr_i[p*ADDR_WIDTH +: ADDR_WIDTH];
                win_pl.we    = s_we_i[p];
                win_pl.be    = s_be_i[p*BE_WIDTH +: BE_WIDTH];
                win_pl.wdata = s_wdata_i[p*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign m_addr_o  = win_pl.addr;
    assign m_we_o    = win_pl.we;
    assign m_be_o    = win_pl.be;
    assign m_wdata_o = win_pl.wdata;

    // Full blocks the request even when a pop lands this cycle.
    assign m_req_o   = win_valid && !fifo_full && !rst_i;
    assign handshake = m_req_o && m_gnt_i;
    assign rsp_ok    = m_rvalid_i && !fifo_empty && !rst_i;
    assign s_rdata_o = m_rdata_i;
    assign err_o     = err_q;

    always_comb begin
        s_gnt_o    = '0;
        s_rvalid_o = '0;
        if (handshake) begin
            s_gnt_o[win_idx] = 1'b1;
        end
        if (rsp_ok) begin
            s_rvalid_o[fifo_head] = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr_q   <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
            err_q      <= 1'b0;
        end else begin
            if (handshake) begin
                rr_ptr_q <= (win_idx == IDX_W'(NUM_PORTS - 1)) ? '0 : win_idx + 1'b1;
                lock_q   <= 1'b0;
            end else if (m_req_o) begin
                lock_q     <= 1'b1;
                lock_idx_q <= win_idx;
            end else if (lock_drop) begin
                lock_q <= 1'b0;
            end
            if (lock_drop || (m_rvalid_i && fifo_empty)) begin
                err_q <= 1'b1;
            end
        end
    end

    gpgpu_idx_fifo #(
        .WIDTH(IDX_W),
        .DEPTH(MAX_OUTSTANDING)
    ) u_idx_fifo (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .push_i (handshake),
        .data_i (win_idx),
        .pop_i  (rsp_ok),
        .head_o (fifo_head),
        .full_o (fifo_full),
        .empty_o(fifo_empty)
    );

endmodule

// File: tb/tb_gpgpu_obi_arbiter.sv
// Directed bench for gpgpu_obi_arbiter: RR order, lock, full FIFO, response
// routing, error flag and reset behaviour.
module tb_gpgpu_obi_arbiter;

    logic          clk = 1'b0;
    logic          rst_i = 1'b1;
    logic [3:0]    s_req_i = '0;
    logic [3:0]    s_gnt_o;
    logic [127:0]  s_addr_i;
    logic [3:0]    s_we_i;
    logic [15:0]   s_be_i;
    logic [127:0]  s_wdata_i;
    logic [3:0]    s_rvalid_o;
    logic [31:0]   s_rdata_o;
    logic          m_req_o;
    logic          m_gnt_i = 1'b0;
    logic [31:0]   m_addr_o;
    logic          m_we_o;
    logic [3:0]    m_be_o;
    logic [31:0]   m_wdata_o;
    logic          m_rvalid_i = 1'b0;
    logic [31:0]   m_rdata_i = '0;
    logic          err_o;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    gpgpu_obi_arbiter #(
        .NUM_PORTS(4),
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .MAX_OUTSTANDING(4)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst_i),
        .s_req_i   (s_req_i),
        .s_gnt_o   (s_gnt_o),
        .s_addr_i  (s_addr_i),
        .s_we_i    (s_we_i),
        .s_be_i    (s_be_i),
        .s_wdata_i (s_wdata_i),
        .s_rvalid_o(s_rvalid_o),
        .s_rdata_o (s_rdata_o),
        .m_req_o   (m_req_o),
        .m_gnt_i   (m_gnt_i),
        .m_addr_o  (m_addr_o),
        .m_we_o    (m_we_o),
        .m_be_o    (m_be_o),
        .m_wdata_o (m_wdata_o),
        .m_rvalid_i(m_rvalid_i),
        .m_rdata_i (m_rdata_i),
        .err_o     (err_o)
    );

    function automatic logic [31:0] addr_of(input int p);
        return 32'h1000_0000 + 32'(p * 16);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    // Apply one cycle of stimulus at the falling edge, then let comb settle.
    task automatic drv(input logic rst, input logic [3:0] req, input logic gnt,
                       input logic rv, input logic [31:0] rd);
        @(negedge clk);
        rst_i      = rst;
        s_req_i    = req;
        m_gnt_i    = gnt;
        m_rvalid_i = rv;
        m_rdata_i  = rd;
        #1;
    endtask

    initial begin
        for (int p = 0; p < 4; p++) begin
            s_addr_i[p*32 +: 32]  = addr_of(p);
            s_wdata_i[p*32 +: 32] = 32'hD0 + 32'(p);
            s_we_i[p]             = p[0];
            s_be_i[p*4 +: 4]      = 4'hF;
        end

        // Reset forces outputs low
        drv(1, 4'b1111, 1, 1, 0);
        chk("rst_mreq", m_req_o, 0);
        chk("rst_gnt", s_gnt_o, 0);
        chk("rst_rvalid", s_rvalid_o, 0);
        drv(1, 4'b0000, 0, 0, 0);
        chk("rst_err", err_o, 0);

        // 1: ports 0 and 2, then responses routed in order
        drv(0, 4'b0101, 1, 0, 0);
        chk("t1_mreq", m_req_o, 1);
        chk("t1_gnt0", s_gnt_o, 4'b0001);
        chk("t1_addr0", m_addr_o, addr_of(0));
        chk("t1_wdata0", m_wdata_o, 32'hD0);
        drv(0, 4'b0100, 1, 0, 0);
        chk("t1_gnt2", s_gnt_o, 4'b0100);
        chk("t1_addr2", m_addr_o, addr_of(2));
        chk("t1_we2", m_we_o, 0);
        drv(0, 4'b0000, 0, 1, 32'hAAAA);
        chk("t1_rv0", s_rvalid_o, 4'b0001);
        chk("t1_rdata", s_rdata_o, 32'hAAAA);
        chk("t1_idle", m_req_o, 0);
        drv(0, 4'b0000, 0, 1, 32'hBBBB);
        chk("t1_rv2", s_rvalid_o, 4'b0100);
        drv(0, 4'b1001, 1, 0, 0);
        chk("t1_rr3", s_gnt_o, 4'b1000);
        drv(0, 4'b0001, 1, 0, 0);
        chk("t1_rr0", s_gnt_o, 4'b0001);
        drv(0, 4'b0000, 0, 1, 1);
        chk("t1_rv3", s_rvalid_o, 4'b1000);
        drv(0, 4'b0000, 0, 1, 2);
        chk("t1_rv0b", s_rvalid_o, 4'b0001);

        // 2: port1 stalled for 3 cycles while port0 joins
        drv(0, 4'b0010, 0, 0, 0);
        chk("t2_mreq", m_req_o, 1);
        chk("t2_nogrant", s_gnt_o, 0);
        chk("t2_addr_c0", m_addr_o, addr_of(1));
        drv(0, 4'b0011, 0, 0, 0);
        chk("t2_addr_c1", m_addr_o, addr_of(1));
        drv(0, 4'b0011, 0, 0, 0);
        chk("t2_addr_c2", m_addr_o, addr_of(1));
        drv(0, 4'b0011, 1, 0, 0);
        chk("t2_gnt1", s_gnt_o, 4'b0010);
        chk("t2_addr_c3", m_addr_o, addr_of(1));
        drv(0, 4'b0001, 1, 0, 0);
        chk("t2_gnt0", s_gnt_o, 4'b0001);
        drv(0, 4'b0000, 0, 1, 0);
        chk("t2_rv1", s_rvalid_o, 4'b0010);
        drv(0, 4'b0000, 0, 1, 0);
        chk("t2_rv0", s_rvalid_o, 4'b0001);

        // 3: all four request with rr_ptr=1, FIFO fills
        drv(0, 4'b1111, 1, 0, 0);
        chk("t3_g1", s_gnt_o, 4'b0010);
        drv(0, 4'b1111, 1, 0, 0);
        chk("t3_g2", s_gnt_o, 4'b0100);
        drv(0, 4'b1111, 1, 0, 0);
        chk("t3_g3", s_gnt_o, 4'b1000);
        drv(0, 4'b1111, 1, 0, 0);
        chk("t3_g0", s_gnt_o, 4'b0001);
        drv(0, 4'b1111, 1, 0, 0);
        chk("t3_full_mreq", m_req_o, 0);
        chk("t3_full_gnt", s_gnt_o, 0);

        // 4: pop while full does not unblock the same cycle
        drv(0, 4'b1111, 1, 1, 32'hC0);
        chk("t4_mreq_pop", m_req_o, 0);
        chk("t4_gnt_pop", s_gnt_o, 0);
        chk("t4_rv1", s_rvalid_o, 4'b0010);
        drv(0, 4'b1111, 1, 0, 0);
        chk("t4_mreq_next", m_req_o, 1);
        chk("t4_gnt_next", s_gnt_o, 4'b0010);
        drv(0, 4'b1111, 1, 0, 0);
        chk("t4_full_again", m_req_o, 0);
        drv(0, 4'b0000, 0, 1, 0);
        chk("t4_d2", s_rvalid_o, 4'b0100);
        drv(0, 4'b0000, 0, 1, 0);
        chk("t4_d3", s_rvalid_o, 4'b1000);
        drv(0, 4'b0000, 0, 1, 0);
        chk("t4_d0", s_rvalid_o, 4'b0001);
        drv(0, 4'b0000, 0, 1, 0);
        chk("t4_d1", s_rvalid_o, 4'b0010);
        chk("t4_err_clean", err_o, 0);

        // 5: stray rvalid with empty FIFO
        drv(0, 4'b0000, 0, 1, 0);
        chk("t5_rv_none", s_rvalid_o, 0);
        drv(0, 4'b0000, 0, 0, 0);
        chk("t5_err_set", err_o, 1);
        drv(0, 4'b0000, 0, 0, 0);
        chk("t5_err_sticky", err_o, 1);

        // 6: reset with two outstanding, rr_ptr=2 beforehand
        drv(0, 4'b0011, 1, 0, 0);
        chk("t6_g0", s_gnt_o, 4'b0001);
        drv(0, 4'b0011, 1, 0, 0);
        chk("t6_g1", s_gnt_o, 4'b0010);
        drv(1, 4'b1111, 1, 1, 0);
        chk("t6_rst_mreq", m_req_o, 0);
        chk("t6_rst_gnt", s_gnt_o, 0);
        chk("t6_rst_rv", s_rvalid_o, 0);
        drv(1, 4'b0000, 0, 0, 0);
        chk("t6_err_clr", err_o, 0);
        drv(0, 4'b0000, 0, 1, 0);
        chk("t6_stray_rv", s_rvalid_o, 0);
        drv(0, 4'b1000, 1, 0, 0);
        chk("t6_stray_err", err_o, 1);
        chk("t6_gnt3", s_gnt_o, 4'b1000);

        // Lock holds against RR, then a withdrawn lock flags an error
        drv(1, 4'b0000, 0, 0, 0);
        drv(0, 4'b0100, 0, 0, 0);
        chk("lk_mreq", m_req_o, 1);
        chk("lk_addr2", m_addr_o, addr_of(2));
        drv(0, 4'b0101, 0, 0, 0);
        chk("lk_hold_addr", m_addr_o, addr_of(2));
        chk("lk_err0", err_o, 0);
        drv(0, 4'b0001, 1, 0, 0);
        chk("lk_drop_addr", m_addr_o, addr_of(0));
        chk("lk_drop_gnt", s_gnt_o, 4'b0001);
        drv(0, 4'b0000, 0, 0, 0);
        chk("lk_drop_err", err_o, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
